// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding and byte-length constant
package i2c_pkg;

    localparam int BIT_CNT = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ACK_ADDR = 3'd2,
        ST_REG      = 3'd3,
        ST_ACK_REG  = 3'd4,
        ST_DATA     = 3'd5,
        ST_ACK_DATA = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - 2-FF synchronizer plus history FF with edge strobes
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic hist_q, hist_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~hist_q;
    assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - I2C write-only target: address match, register pointer, data bytes
import i2c_pkg::*;

module i2c_target_rx #(
    parameter logic [6:0] DEV_ID = 7'h50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [7:0] states
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .din   (scl_in),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .din   (sda_in),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       ack_q, ack_d;
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_reg_q, wr_reg_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       busy_q, busy_d;

    logic       start_det, stop_det, byte_done;
    logic [7:0] new_byte;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign byte_done = scl_rise && (cnt_q == 4'(BIT_CNT - 1));
    assign new_byte  = {shift_q[6:0], sda_lvl};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        ack_d      = ack_q;
        wr_valid_d = 1'b0;
        wr_reg_d   = wr_reg_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            ST_ADDR, ST_REG, ST_DATA: begin
                if (scl_rise) begin
                    shift_d = new_byte;
                    cnt_d   = cnt_q + 4'd1;
                end
                if (byte_done) begin
                    cnt_d = '0;
                    case (state_q)
                        ST_ADDR: begin
                            if (new_byte[7:1] == DEV_ID && !new_byte[0])
                                state_d = ST_ACK_ADDR;
                            else
                                state_d = ST_IGNORE;
                        end
                        ST_REG: begin
                            ptr_d   = new_byte;
                            state_d = ST_ACK_REG;
                        end
                        default: begin
                            wr_valid_d = 1'b1;
                            wr_reg_d   = ptr_q;
                            wr_data_d  = new_byte;
                            ptr_d      = ptr_q + 8'd1;
                            state_d    = ST_ACK_DATA;
                        end
                    endcase
                end
            end
            // First SCL fall after the 8th bit grabs SDA, the next one (after the 9th clock) lets go.
            ST_ACK_ADDR, ST_ACK_REG, ST_ACK_DATA: begin
                if (scl_fall) begin
                    if (!ack_q) begin
                        ack_d = 1'b1;
                    end else begin
                        ack_d   = 1'b0;
                        state_d = (state_q == ST_ACK_ADDR) ? ST_REG : ST_DATA;
                    end
                end
            end
            default: ;
        endcase

        if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            ack_d   = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ack_d   = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            ack_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_reg_q   <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            wr_valid_q <= wr_valid_d;
            wr_reg_q   <= wr_reg_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe   = ack_q;
    assign wr_valid = wr_valid_q;
    assign wr_reg   = wr_reg_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign states   = {5'd0, state_q};

endmodule
